// File: rtl/multi_pipe_painter.sv
// Flappy-box frame painter: erases the previous pipes and box, then redraws
// them at the latched positions, one pixel slot per clock.
module multi_pipe_painter #(
    parameter int NUM_PIPES = 2,
    parameter int PIPE_W    = 4,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int GAP_H     = 24,
    parameter int BOX_X     = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   game_pulse,
    input  logic [6:0]             box_y,
    input  logic [9*NUM_PIPES-1:0] pipe_x,
    input  logic [7*NUM_PIPES-1:0] pipe_gap_y,
    output logic                   plot,
    output logic [8:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int CW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;
    localparam logic [PW-1:0] LAST_PIPE = PW'(NUM_PIPES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(PIPE_W - 1);
    localparam logic [6:0]    LAST_ROW  = 7'(SCREEN_H - 1);
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_EP, S_EB, S_DP, S_DB, S_DONE
    } state_t;

    state_t        r_state;
    logic          r_prev_valid;
    logic [PW-1:0] r_pipe;
    logic [CW-1:0] r_col;
    logic [6:0]    r_row;
    logic [1:0]    r_bc;
    logic [1:0]    r_br;

    logic [8:0] r_cur_px [NUM_PIPES];
    logic [6:0] r_cur_gy [NUM_PIPES];
    logic [6:0] r_cur_by;
    logic [8:0] r_sh_px  [NUM_PIPES];
    logic [6:0] r_sh_gy  [NUM_PIPES];
    logic [6:0] r_sh_by;

    logic       w_erase;
    logic       w_box;
    logic [8:0] w_sel_px;
    logic [6:0] w_sel_gy;
    logic [6:0] w_sel_by;
    logic [9:0] w_px;
    logic [7:0] w_row8;
    logic [7:0] w_gtop;
    logic [7:0] w_gbot;
    logic       w_pipe_plot;
    logic [9:0] w_bx;
    logic [7:0] w_by;
    logic       w_box_plot;
    logic       w_plot;
    logic [8:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_colour;
    logic       w_pipe_last;
    logic       w_box_last;

    always_comb begin
        w_erase  = (r_state == S_EP) || (r_state == S_EB);
        w_box    = (r_state == S_EB) || (r_state == S_DB);
        w_sel_px = w_erase ? r_sh_px[r_pipe] : r_cur_px[r_pipe];
        w_sel_gy = w_erase ? r_sh_gy[r_pipe] : r_cur_gy[r_pipe];
        w_sel_by = w_erase ? r_sh_by : r_cur_by;
        // Pipe slot: 10-bit column so pipes near the right edge never wrap
        w_px   = {1'b0, w_sel_px} + 10'(r_col);
        w_row8 = {1'b0, r_row};
        w_gtop = {1'b0, w_sel_gy};
        w_gbot = w_gtop + 8'(GAP_H - 1);
        w_pipe_plot = (w_px < 10'(SCREEN_W)) &&
                      !((w_row8 >= w_gtop) && (w_row8 <= w_gbot));
        // Box slot: row -1 wraps to 255 in 8 bits and is then off-screen
        w_bx = 10'(BOX_X - 1) + 10'(r_bc);
        w_by = {1'b0, w_sel_by} + 8'(r_br) - 8'd1;
        w_box_plot = (w_by < 8'(SCREEN_H)) && (w_bx < 10'(SCREEN_W));
        w_plot   = w_box ? w_box_plot : w_pipe_plot;
        w_x      = w_box ? w_bx[8:0] : w_px[8:0];
        w_y      = w_box ? w_by[6:0] : r_row;
        w_colour = w_erase ? BLACK : (w_box ? YELLOW : GREEN);
        w_pipe_last = (r_row == LAST_ROW) && (r_col == LAST_COL) &&
                      (r_pipe == LAST_PIPE);
        w_box_last  = (r_bc == 2'd2) && (r_br == 2'd2);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prev_valid <= 1'b0;
            r_pipe       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_bc         <= '0;
            r_br         <= '0;
            r_cur_by     <= '0;
            r_sh_by      <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_cur_px[i] <= '0;
                r_cur_gy[i] <= '0;
                r_sh_px[i]  <= '0;
                r_sh_gy[i]  <= '0;
            end
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= BLACK;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (game_pulse && !busy) r_state <= S_LATCH;
                end
                S_LATCH: begin
                    plot <= 1'b0;
                    busy <= 1'b1;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        r_cur_px[i] <= pipe_x[9*i +: 9];
                        r_cur_gy[i] <= pipe_gap_y[7*i +: 7];
                    end
                    r_cur_by <= box_y;
                    r_pipe   <= '0;
                    r_col    <= '0;
                    r_row    <= '0;
                    r_bc     <= '0;
                    r_br     <= '0;
                    r_state  <= r_prev_valid ? S_EP : S_DP;
                end
                S_EP, S_DP: begin
                    plot <= w_plot;
                    if (w_plot) begin
                        x      <= w_x;
                        y      <= w_y;
                        colour <= w_colour;
                    end
                    if (r_row == LAST_ROW) begin
                        r_row <= '0;
                        if (r_col == LAST_COL) begin
                            r_col  <= '0;
                            r_pipe <= (r_pipe == LAST_PIPE) ? '0 : r_pipe + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                    if (w_pipe_last)
                        r_state <= (r_state == S_EP) ? S_EB : S_DB;
                end
                S_EB, S_DB: begin
                    plot <= w_plot;
                    if (w_plot) begin
                        x      <= w_x;
                        y      <= w_y;
                        colour <= w_colour;
                    end
                    if (r_br == 2'd2) begin
                        r_br <= '0;
                        r_bc <= (r_bc == 2'd2) ? 2'd0 : r_bc + 1'b1;
                    end else begin
                        r_br <= r_br + 1'b1;
                    end
                    if (w_box_last)
                        r_state <= (r_state == S_EB) ? S_DP : S_DONE;
                end
                S_DONE: begin
                    plot         <= 1'b0;
                    frame_done   <= 1'b1;
                    r_prev_valid <= 1'b1;
                    r_sh_by      <= r_cur_by;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        r_sh_px[i] <= r_cur_px[i];
                        r_sh_gy[i] <= r_cur_gy[i];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_pipe_painter.sv
// Scoreboard bench for multi_pipe_painter: expected pixels are queued by the
// stimulus and popped by a negedge monitor whenever plot is high.
module tb_multi_pipe_painter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        game_pulse = 1'b0;
    logic [6:0]  box_y = '0;
    logic [17:0] pipe_x = '0;
    logic [13:0] pipe_gap_y = '0;
    logic        plot;
    logic [8:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        busy;
    logic        frame_done;

    multi_pipe_painter dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .game_pulse(game_pulse),
        .box_y     (box_y),
        .pipe_x    (pipe_x),
        .pipe_gap_y(pipe_gap_y),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [18:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;
    int fd_cnt = 0;
    int pix_cnt = 0;
    int black_cnt = 0;
    int yel_cnt = 0;
    int x40g_cnt = 0;

    int  sh_px0, sh_px1, sh_gy0, sh_gy1, sh_by;
    bit  sh_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [18:0] e;
        if (busy) busy_cnt++;
        if (frame_done) fd_cnt++;
        if (plot) begin
            pix_cnt++;
            if (colour == 3'b000) black_cnt++;
            if (colour == 3'b110) yel_cnt++;
            if (colour == 3'b010 && x == 9'd40) x40g_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected pixel: x=%0d y=%0d c=%0d",
                         x, y, colour);
            end else begin
                e = sb.pop_front();
                if (e != {x, y, colour}) begin
                    n_bad++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             x, y, colour, e[18:10], e[9:3], e[2:0]);
                end
            end
        end
    end

    task automatic push_set(input int p0, input int p1, input int g0,
                            input int g1, input int by,
                            input logic [2:0] cp, input logic [2:0] cb);
        int px, gy, xx, yy;
        for (int p = 0; p < 2; p++) begin
            px = (p == 0) ? p0 : p1;
            gy = (p == 0) ? g0 : g1;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 120; r++) begin
                    xx = px + c;
                    if (xx < 160 && !(r >= gy && r <= gy + 23))
                        sb.push_back({9'(xx), 7'(r), cp});
                end
        end
        for (int bc = 0; bc < 3; bc++)
            for (int br = 0; br < 3; br++) begin
                yy = by - 1 + br;
                if (yy >= 0 && yy < 120)
                    sb.push_back({9'(3 + bc), 7'(yy), cb});
            end
    endtask

    task automatic clr_cnt();
        busy_cnt = 0; fd_cnt = 0; pix_cnt = 0;
        black_cnt = 0; yel_cnt = 0; x40g_cnt = 0;
    endtask

    task automatic start_frame(input int p0, input int p1, input int g0,
                               input int g1, input int by);
        @(posedge clk); #1;
        pipe_x     = {9'(p1), 9'(p0)};
        pipe_gap_y = {7'(g1), 7'(g0)};
        box_y      = 7'(by);
        if (sh_valid)
            push_set(sh_px0, sh_px1, sh_gy0, sh_gy1, sh_by, 3'b000, 3'b000);
        push_set(p0, p1, g0, g1, by, 3'b010, 3'b110);
        sh_px0 = p0; sh_px1 = p1; sh_gy0 = g0; sh_gy1 = g1; sh_by = by;
        sh_valid = 1;
        clr_cnt();
        game_pulse = 1'b1;
    endtask

    task automatic do_frame(input string tag, input int p0, input int p1,
                            input int g0, input int g1, input int by,
                            input int inject, input int e_busy,
                            input int e_pix, input int e_black,
                            input int e_yel, input int e_x40g);
        bit done = 0;
        start_frame(p0, p1, g0, g1, by);
        for (int k = 0; k < 4000 && !done; k++) begin
            @(posedge clk); #1;
            game_pulse = (k == inject);
            if (frame_done) done = 1;
        end
        game_pulse = 1'b0;
        if (!done) chk({tag, " frame_done timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " busy cycles"}, busy_cnt, e_busy);
        chk({tag, " frame_done pulses"}, fd_cnt, 1);
        chk({tag, " plotted"}, pix_cnt, e_pix);
        chk({tag, " black"}, black_cnt, e_black);
        chk({tag, " yellow"}, yel_cnt, e_yel);
        chk({tag, " green x40"}, x40g_cnt, e_x40g);
        chk({tag, " queue left"}, sb.size(), 0);
        chk({tag, " busy low"}, int'(busy), 0);
    endtask

    initial begin
        int bad_idle;
        bit hit;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset plot", int'(plot), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset colour", int'(colour), 0);
        chk("reset x", int'(x), 0);
        bad_idle = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (plot || busy || frame_done) bad_idle++;
        end
        chk("idle quiet", bad_idle, 0);

        do_frame("f1", 40, 100, 30, 60, 50, -1, 971, 777, 0, 9, 96);
        do_frame("f2", 39, 99, 30, 60, 50, 300, 1940, 1554, 777, 9, 96);
        do_frame("f3", 158, 20, 110, 0, 0, -1, 1940, 1387, 777, 6, 0);

        // Abort a frame part-way with reset
        start_frame(158, 20, 110, 0, 0);
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(posedge clk); #1;
            game_pulse = 1'b0;
            if (busy_cnt >= 501) hit = 1;
        end
        chk("reach slot 500", int'(hit), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        sh_valid = 0;
        chk("abort plot", int'(plot), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(frame_done), 0);
        repeat (3) @(posedge clk);

        do_frame("f5", 158, 20, 110, 0, 0, -1, 971, 610, 0, 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
